// File: rtl/ula_contention_gen.sv
`default_nettype none
// ============================================================================
// Module   : ula_contention_gen
// Brief    : ULA beam counters, CPU contention and frame interrupt generation.
//            Optional Pentagon timing enabled by defining PENTAGON_TIMING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ula_contention_gen #(
    parameter int HC_CONT_START = 0,
    parameter int INT_LINE_48K  = 248,
    parameter int INT_LINE_PENT = 239,
    parameter int H_TOTAL_48K   = 448,
    parameter int V_TOTAL_48K   = 312,
    parameter int H_TOTAL_128K  = 456,
    parameter int V_TOTAL_128K  = 311,
    parameter int H_TOTAL_PENT  = 448,
    parameter int V_TOTAL_PENT  = 320,
    parameter int PAPER_LINES   = 192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk7en,
    input  logic [1:0]  timing_mode,
    input  logic [15:0] a,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        bank_contended,
    output logic        cpu_contention,
    output logic        int_n,
    output logic [8:0]  hc,
    output logic [8:0]  vc
);

    localparam logic [1:0] c_MODE_48K  = 2'd0;
    localparam logic [1:0] c_MODE_128K = 2'd1;
    localparam logic [1:0] c_MODE_PENT = 2'd2;

    logic [8:0] r_hc;
    logic [8:0] r_vc;
    logic [1:0] r_mode;
    logic       r_cont;
    logic       r_int_n;
    logic [6:0] r_int_cnt;

    logic [1:0] w_mode_sel;
    logic [9:0] w_h_last;
    logic [9:0] w_v_last;
    logic [8:0] w_int_line;
    logic [8:0] w_int_start;
    logic [6:0] w_int_len;
    logic       w_hc_wrap;
    logic       w_vc_wrap;
    logic [9:0] w_hc_rel;
    logic       w_slot;
    logic [1:0] w_page;
    logic       w_mem;
    logic       w_io;
    logic       w_cont;
    logic       w_int_hit;
    logic       w_unused_a;

    // Requested mode; only copied into r_mode at reset and frame wrap.
    always_comb begin
        w_mode_sel = c_MODE_48K;
        if (timing_mode == 2'b01) begin
            w_mode_sel = c_MODE_128K;
        end
`ifdef PENTAGON_TIMING_EN
        else if (timing_mode == 2'b10) begin
            w_mode_sel = c_MODE_PENT;
        end
`endif
    end

    always_comb begin
        w_h_last    = 10'(H_TOTAL_48K - 1);
        w_v_last    = 10'(V_TOTAL_48K - 1);
        w_int_line  = 9'(INT_LINE_48K);
        w_int_start = 9'd0;
        w_int_len   = 7'd64;
        case (r_mode)
            c_MODE_128K: begin
                w_h_last    = 10'(H_TOTAL_128K - 1);
                w_v_last    = 10'(V_TOTAL_128K - 1);
                w_int_start = 9'd4;
                w_int_len   = 7'd72;
            end
            c_MODE_PENT: begin
                w_h_last   = 10'(H_TOTAL_PENT - 1);
                w_v_last   = 10'(V_TOTAL_PENT - 1);
                w_int_line = 9'(INT_LINE_PENT);
            end
            default: ;
        endcase
    end

    assign w_hc_wrap = ({1'b0, r_hc} >= w_h_last);
    assign w_vc_wrap = ({1'b0, r_vc} >= w_v_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc   <= '0;
            r_vc   <= '0;
            r_mode <= w_mode_sel;
        end else if (clk7en) begin
            if (w_hc_wrap) begin
                r_hc <= '0;
                if (w_vc_wrap) begin
                    r_vc   <= '0;
                    r_mode <= w_mode_sel;
                end else begin
                    r_vc <= r_vc + 9'd1;
                end
            end else begin
                r_hc <= r_hc + 9'd1;
            end
        end
    end

    // Columns left of the window wrap to a large value, so one compare covers both edges.
    assign w_hc_rel = {1'b0, r_hc} - 10'(HC_CONT_START);
    assign w_slot   = (r_vc < 9'(PAPER_LINES)) && (w_hc_rel < 10'd256) && (w_hc_rel[3:0] < 4'd12);

    assign w_page = a[15:14];
    assign w_mem  = !mreq_n && ((w_page == 2'b01) ||
                    ((w_page == 2'b11) && bank_contended && (r_mode == c_MODE_128K)));
    assign w_io   = !iorq_n && (!a[0] || (w_page == 2'b01));
    assign w_cont = w_slot && (w_mem || w_io) && (r_mode != c_MODE_PENT);

    assign w_unused_a = &{1'b0, a[13:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cont <= 1'b0;
        end else begin
            r_cont <= w_cont;
        end
    end

    // The pulse length is counted in pixel clocks so it survives a line wrap.
    assign w_int_hit = (r_vc == w_int_line) && (r_hc == w_int_start);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_cnt <= '0;
            r_int_n   <= 1'b1;
        end else if (r_int_cnt != 7'd0) begin
            if (clk7en) begin
                r_int_cnt <= r_int_cnt - 7'd1;
            end
            r_int_n <= 1'b0;
        end else if (w_int_hit && r_int_n) begin
            r_int_cnt <= clk7en ? (w_int_len - 7'd1) : w_int_len;
            r_int_n   <= 1'b0;
        end else begin
            r_int_n <= 1'b1;
        end
    end

    assign hc             = r_hc;
    assign vc             = r_vc;
    assign cpu_contention = r_cont;
    assign int_n          = r_int_n;

endmodule
`default_nettype wire
